sha1_msg_padder: RTL and testbench
==================================

// Module: sha1_msg_padder
// PURPOSE
//  Transmit side of the SHA-1 chunk interface: feeds the SHA-1 top (msg/start/is_first/is_last/busy).
//  Accepts a byte-oriented message as a 32-bit big-endian word stream (valid/ready, last, byte count).
//  Assembles 512-bit chunks and applies FIPS 180-4 padding: 0x80, zeros, 64-bit bit length.
//  Issues each chunk with a 1-cycle start pulse, only while the hash engine is not busy.
// PARAMETERS
//  LEN_W   61   byte-counter width; bit length = {cnt,3'b000}, wraps mod 2^64
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-high
//  s_data_i     in   32   message word; [31:24] = earliest byte
//  s_valid_i    in   1    s_data_i valid
//  s_last_i     in   1    final word of message
//  s_bytes_i    in   3    valid bytes in final word, 0..4 (ignored unless s_last_i; 0 = none)
//  s_ready_o    out  1    word accepted when s_valid_i & s_ready_o
//  msg_o        out  512  chunk; word 0 at [511:480]; stable from start_o to the next start_o
//  start_o      out  1    1-cycle pulse: msg_o/is_first_o/is_last_o valid
//  is_first_o   out  1    chunk is first of message; held with msg_o
//  is_last_o    out  1    chunk is last of message; held with msg_o
//  hash_busy_i  in   1    engine busy; no start_o while high
// BEHAVIOUR
//  Reset: msg_o=0, start_o=0, is_first_o=0, is_last_o=0, s_ready_o=0; state FILL, word idx=0,
//   byte cnt=0, first_pend=1, extra_pend=0. s_ready_o=1 from the first cycle after reset release.
//  States: FILL, ISSUE, GUARD.
//  FILL: s_ready_o=1. Accepted word goes into build-buffer word idx; idx++; cnt += 4, or s_bytes_i if last.
//   Non-last accept at idx 15 -> ISSUE with last_flag=0.
//   Last accept: b = idx*4 + s_bytes_i, the data bytes in this chunk (0..64).
//    b<64: byte b=0x80; bytes above b and below 56 = 0. Non-valid bytes of the partial word are overwritten.
//    b<=55: bytes 56..63 = cnt*8 (big-endian, includes this word); last_flag=1.
//    56<=b<=63: last_flag=0, extra_pend=1, extra_80=0.
//    b==64: last_flag=0, extra_pend=1, extra_80=1.
//   Then -> ISSUE.
//  ISSUE: s_ready_o=0. When hash_busy_i==0: load msg_o <= buffer, is_first_o <= first_pend,
//   is_last_o <= last_flag; pulse start_o next cycle, aligned with the new msg_o; clear first_pend -> GUARD.
//  GUARD: exactly 1 cycle. Busy is never sampled in the cycle after start_o.
//   extra_pend: build extra chunk = bytes 0..55 zero (byte 0=0x80 if extra_80), bytes 56..63 = cnt*8;
//    last_flag=1; extra_pend=0 -> ISSUE.
//   else last_flag=1: cnt=0, idx=0, first_pend=1 -> FILL.
//   else: idx=0 -> FILL, cnt kept.
//  Length arithmetic mod 2^64; cnt overflow wraps silently.
//  s_bytes_i>4 is treated as 4. s_valid_i while s_ready_o=0 is held off; no data loss.
//  Reset mid-message discards all state; the next accepted word starts a new message (is_first_o=1).
//  Back-to-back messages: first word of the next message is accepted the cycle after GUARD.
// TESTING
//  1 Empty: word with last=1, bytes=0 -> one start_o; msg_o=512'h8<<508; first=last=1.
//  2 "abc": 32'h61626300, last, bytes=3 -> msg_o word0=32'h61626380, words1..14=0,
//    word15=32'h18; first=last=1.
//  3 56 bytes: 14 words, last bytes=4 -> chunk1: word14=32'h80000000, word15=0, last=0;
//    chunk2: words0..14=0, word15=32'h1C0, first=0, last=1.
//  4 64 bytes: 16 words -> chunk1 all data, last=0; chunk2: word0=32'h80000000,
//    word15=32'h200, last=1.
//  5 Backpressure: hash_busy_i=1 for 10 cycles in ISSUE -> no start_o, s_ready_o=0;
//    start_o 1 cycle after busy falls; msg_o stable until next start_o.
//  6 Reset after 5 words, then "abc" -> all outputs 0 during reset; one chunk first=1,
//    word15=32'h18 (old bytes not counted).

Source files
------------

// File: rtl/sha1_msg_padder.sv
// SHA-1 transmit-side message padder: packs a 32-bit big-endian word stream into
// 512-bit chunks, appends FIPS 180-4 padding and hands each chunk to the hash engine.
module sha1_msg_padder #(
    parameter int unsigned LEN_W = 61
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  s_data_i,
    input  logic         s_valid_i,
    input  logic         s_last_i,
    input  logic [2:0]   s_bytes_i,
    output logic         s_ready_o,
    output logic [511:0] msg_o,
    output logic         start_o,
    output logic         is_first_o,
    output logic         is_last_o,
    input  logic         hash_busy_i
);
    localparam int unsigned CHUNK_W = 512;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned B_W     = 7;
    localparam int unsigned BLEN_W  = 64;

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        GUARD
    } state_e;

    state_e               state_q, state_d;
    logic [CHUNK_W-1:0]   bld_q, bld_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 first_pend_q, first_pend_d;
    logic                 extra_pend_q, extra_pend_d;
    logic                 extra_80_q, extra_80_d;
    logic                 last_flag_q, last_flag_d;
    logic                 ready_q, ready_d;
    logic [CHUNK_W-1:0]   msg_q, msg_d;
    logic                 start_q, start_d;
    logic                 is_first_q, is_first_d;
    logic                 is_last_q, is_last_d;

    logic                 accept;
    logic [2:0]           bytes_eff;
    logic [LEN_W-1:0]     cnt_acc;
    logic [B_W-1:0]       b;
    logic [BLEN_W-1:0]    len_acc;
    logic [BLEN_W-1:0]    len_cur;
    logic [CHUNK_W-1:0]   wr_bld;
    logic [CHUNK_W-1:0]   pad_bld;
    logic [CHUNK_W-1:0]   extra_bld;

    assign s_ready_o  = ready_q;
    assign msg_o      = msg_q;
    assign start_o    = start_q;
    assign is_first_o = is_first_q;
    assign is_last_o  = is_last_q;

    // Byte accounting for the word offered this cycle
    assign accept    = s_valid_i & ready_q;
    assign bytes_eff = (s_bytes_i > 3'd4) ? 3'd4 : s_bytes_i;
    assign cnt_acc   = cnt_q + (s_last_i ? LEN_W'(bytes_eff) : LEN_W'(4));
    assign b         = {1'b0, idx_q, 2'b00} + B_W'(bytes_eff);
    assign len_acc   = BLEN_W'({cnt_acc, 3'b000});
    assign len_cur   = BLEN_W'({cnt_q, 3'b000});

    // Build buffer with the incoming word, and its padded variant for a final word
    always_comb begin
        wr_bld = bld_q;
        wr_bld[{4'd15 - idx_q, 5'd0} +: WORD_W] = s_data_i;
        pad_bld = wr_bld;
        for (int k = 0; k < 64; k++) begin
            if (B_W'(k) == b) begin
                pad_bld[(63 - k) * 8 +: 8] = 8'h80;
            end else if (B_W'(k) > b) begin
                if (b <= B_W'(55) && k >= 56) begin
                    pad_bld[(63 - k) * 8 +: 8] = len_acc[(63 - k) * 8 +: 8];
                end else begin
                    pad_bld[(63 - k) * 8 +: 8] = 8'h00;
                end
            end
        end
    end

    // Trailing chunk when the length field did not fit after the data
    always_comb begin
        extra_bld                              = '0;
        extra_bld[BLEN_W-1:0]                  = len_cur;
        extra_bld[CHUNK_W-1 -: 8]              = extra_80_q ? 8'h80 : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            bld_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            first_pend_q <= 1'b1;
            extra_pend_q <= 1'b0;
            extra_80_q   <= 1'b0;
            last_flag_q  <= 1'b0;
            ready_q      <= 1'b0;
            msg_q        <= '0;
            start_q      <= 1'b0;
            is_first_q   <= 1'b0;
            is_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bld_q        <= bld_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            first_pend_q <= first_pend_d;
            extra_pend_q <= extra_pend_d;
            extra_80_q   <= extra_80_d;
            last_flag_q  <= last_flag_d;
            ready_q      <= ready_d;
            msg_q        <= msg_d;
            start_q      <= start_d;
            is_first_q   <= is_first_d;
            is_last_q    <= is_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bld_d        = bld_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        first_pend_d = first_pend_q;
        extra_pend_d = extra_pend_q;
        extra_80_d   = extra_80_q;
        last_flag_d  = last_flag_q;
        msg_d        = msg_q;
        start_d      = 1'b0;
        is_first_d   = is_first_q;
        is_last_d    = is_last_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    idx_d = IDX_W'(idx_q + 4'd1);
                    cnt_d = cnt_acc;
                    if (s_last_i) begin
                        bld_d   = pad_bld;
                        state_d = ISSUE;
                        if (b <= B_W'(55)) begin
                            last_flag_d = 1'b1;
                        end else begin
                            last_flag_d  = 1'b0;
                            extra_pend_d = 1'b1;
                            extra_80_d   = (b == B_W'(64));
                        end
                    end else begin
                        bld_d = wr_bld;
                        if (idx_q == 4'd15) begin
                            last_flag_d = 1'b0;
                            state_d     = ISSUE;
                        end
                    end
                end
            end
            ISSUE: begin
                if (!hash_busy_i) begin
                    msg_d        = bld_q;
                    is_first_d   = first_pend_q;
                    is_last_d    = last_flag_q;
                    start_d      = 1'b1;
                    first_pend_d = 1'b0;
                    state_d      = GUARD;
                end
            end
            GUARD: begin
                // Engine has not yet raised busy for the chunk just issued
                if (extra_pend_q) begin
                    bld_d        = extra_bld;
                    last_flag_d  = 1'b1;
                    extra_pend_d = 1'b0;
                    state_d      = ISSUE;
                end else if (last_flag_q) begin
                    cnt_d        = '0;
                    idx_d        = '0;
                    first_pend_d = 1'b1;
                    state_d      = FILL;
                end else begin
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        ready_d = (state_d == FILL);
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: hand-computed padded chunks checked with immediate assertions.
module tb_sha1_msg_padder;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [2:0]   s_bytes;
    logic         s_ready_o;
    logic [511:0] msg_o;
    logic         start_o;
    logic         is_first_o;
    logic         is_last_o;
    logic         hash_busy;

    int n_checks = 0;
    int n_fail   = 0;

    sha1_msg_padder #(.LEN_W(61)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_last_i    (s_last),
        .s_bytes_i   (s_bytes),
        .s_ready_o   (s_ready_o),
        .msg_o       (msg_o),
        .start_o     (start_o),
        .is_first_o  (is_first_o),
        .is_last_o   (is_last_o),
        .hash_busy_i (hash_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] setw(input logic [511:0] m, input int i, input logic [31:0] w);
        logic [511:0] r;
        r = m;
        r[(15 - i) * 32 +: 32] = w;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the word was accepted
    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] nb);
        int n;
        n = 0;
        s_data  = d;
        s_last  = l;
        s_bytes = nb;
        s_valid = 1'b1;
        while (s_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 512'(n), 512'(0));
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start_o !== 1'b1 && n < 50);
        chk({tag, "_start"}, 512'(start_o), 512'(1));
    endtask

    task automatic chk_chunk(input string tag, input logic [511:0] exp, input logic f, input logic l);
        chk({tag, "_msg"}, msg_o, exp);
        chk({tag, "_first"}, 512'(is_first_o), 512'(f));
        chk({tag, "_last"}, 512'(is_last_o), 512'(l));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_msg"}, msg_o, '0);
        chk({tag, "_start"}, 512'(start_o), 512'(0));
        chk({tag, "_first"}, 512'(is_first_o), 512'(0));
        chk({tag, "_last"}, 512'(is_last_o), 512'(0));
        chk({tag, "_ready"}, 512'(s_ready_o), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] exp;
        logic [511:0] prev;
        logic         quiet;

        reset     = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_bytes   = '0;
        hash_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 512'(s_ready_o), 512'(1));

        // Empty message
        send(32'h0, 1'b1, 3'd0);
        wait_start("t1");
        exp = 512'h8 << 508;
        chk_chunk("t1", exp, 1'b1, 1'b1);
        @(negedge clk);
        chk("t1_pulse_end", 512'(start_o), 512'(0));

        // "abc"
        send(32'h61626300, 1'b1, 3'd3);
        wait_start("t2");
        exp = setw('0, 0, 32'h61626380);
        exp = setw(exp, 15, 32'h18);
        chk_chunk("t2", exp, 1'b1, 1'b1);

        // 56 bytes: 0x80 lands at byte 56, length in a second chunk
        for (int i = 0; i < 14; i++) send(32'hA000_0000 | 32'(i), i == 13, 3'd4);
        wait_start("t3a");
        exp = '0;
        for (int i = 0; i < 14; i++) exp = setw(exp, i, 32'hA000_0000 | 32'(i));
        exp = setw(exp, 14, 32'h80000000);
        chk_chunk("t3a", exp, 1'b1, 1'b0);
        wait_start("t3b");
        exp = setw('0, 15, 32'h1C0);
        chk_chunk("t3b", exp, 1'b0, 1'b1);

        // 64 bytes: whole chunk of data, padding entirely in the second chunk
        for (int i = 0; i < 16; i++) send(32'hB000_0000 | 32'(i), i == 15, 3'd4);
        wait_start("t4a");
        exp = '0;
        for (int i = 0; i < 16; i++) exp = setw(exp, i, 32'hB000_0000 | 32'(i));
        chk_chunk("t4a", exp, 1'b1, 1'b0);
        wait_start("t4b");
        exp = setw('0, 0, 32'h80000000);
        exp = setw(exp, 15, 32'h200);
        chk_chunk("t4b", exp, 1'b0, 1'b1);
        prev = exp;

        // Backpressure: "ab" held in ISSUE while the engine is busy
        hash_busy = 1'b1;
        send(32'h61620000, 1'b1, 3'd2);
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (start_o !== 1'b0 || s_ready_o !== 1'b0 || msg_o !== prev) quiet = 1'b0;
            @(negedge clk);
        end
        chk("t5_held_off", 512'(quiet), 512'(1));
        hash_busy = 1'b0;
        @(negedge clk);
        chk("t5_start_after_busy", 512'(start_o), 512'(1));
        exp = setw('0, 0, 32'h61628000);
        exp = setw(exp, 15, 32'h10);
        chk_chunk("t5", exp, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_msg_stable", msg_o, exp);

        // Reset mid-message discards the partial message
        for (int i = 0; i < 5; i++) send(32'hC000_0000 | 32'(i), 1'b0, 3'd4);
        reset = 1'b1;
        #1;
        chk_reset_outputs("t6_rst_async");
        repeat (2) @(negedge clk);
        chk_reset_outputs("t6_rst_held");
        reset = 1'b0;
        send(32'h61626300, 1'b1, 3'd3);
        wait_start("t6");
        exp = setw('0, 0, 32'h61626380);
        exp = setw(exp, 15, 32'h18);
        chk_chunk("t6", exp, 1'b1, 1'b1);

        // Byte count above 4 is clamped to 4
        send(32'hDEADBEEF, 1'b1, 3'd7);
        wait_start("t7");
        exp = setw('0, 0, 32'hDEADBEEF);
        exp = setw(exp, 1, 32'h80000000);
        exp = setw(exp, 15, 32'h20);
        chk_chunk("t7", exp, 1'b1, 1'b1);

        // 59 bytes: partial final word overwritten by 0x80, length spills over
        for (int i = 0; i < 15; i++) send(32'hE000_0000 | 32'(i), i == 14, 3'd3);
        wait_start("t8a");
        exp = '0;
        for (int i = 0; i < 14; i++) exp = setw(exp, i, 32'hE000_0000 | 32'(i));
        exp = setw(exp, 14, 32'hE0000080);
        chk_chunk("t8a", exp, 1'b1, 1'b0);
        wait_start("t8b");
        exp = setw('0, 15, 32'h1D8);
        chk_chunk("t8b", exp, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
